// File: rtl/bit_reverse_reorder.sv
// Purpose     : reorder each N-sample complex frame from natural order into bit-reversed order.
// Latency     : first output 2 cycles after the last sample of a frame is accepted.
// Backpressure: none; a ping-pong bank pair absorbs back-to-back frames with no stall.
//
// Ports:
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   input_en/real/imag       : natural-order sample stream (gaps allowed between samples)
//   output_en/real/imag      : bit-reversed stream, N contiguous valid cycles per frame
//   frame_start              : one-cycle pulse on the first output sample of each frame
//
// N must be a power of two (>= 4) and equal to 2**LOG2N.
module bit_reverse_reorder #(
    parameter int WIDTH = 32,
    parameter int N     = 256,
    parameter int LOG2N = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    input_en,
    input  logic signed [WIDTH-1:0] input_real,
    input  logic signed [WIDTH-1:0] input_imag,
    output logic                    output_en,
    output logic signed [WIDTH-1:0] output_real,
    output logic signed [WIDTH-1:0] output_imag,
    output logic                    frame_start
);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } sample_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } rd_state_e;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Storage: two banks, never cleared; bank 0 = A, bank 1 = B
    // ------------------------------------------------------------------
    sample_t bank_a_mem [N];
    sample_t bank_b_mem [N];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             handover_q, handover_d;
    logic             handover_bank_q, handover_bank_d;
    logic             wr_last;
    sample_t          wr_dat;

    assign wr_dat  = '{re: input_real, im: input_imag};
    assign wr_last = input_en && (wr_cnt_q == CNT_LAST);

    always_comb begin
        wr_cnt_d        = wr_cnt_q;
        wr_bank_d       = wr_bank_q;
        handover_d      = 1'b0;
        handover_bank_d = handover_bank_q;
        if (input_en) begin
            // Counter wraps to 0 on its own after the last sample.
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (wr_last) begin
            wr_bank_d       = ~wr_bank_q;
            handover_d      = 1'b1;
            handover_bank_d = wr_bank_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_q        <= '0;
            wr_bank_q       <= 1'b0;
            handover_q      <= 1'b0;
            handover_bank_q <= 1'b0;
        end else begin
            wr_cnt_q        <= wr_cnt_d;
            wr_bank_q       <= wr_bank_d;
            handover_q      <= handover_d;
            handover_bank_q <= handover_bank_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && input_en && !wr_bank_q) begin
            bank_a_mem[wr_cnt_q] <= wr_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && input_en && wr_bank_q) begin
            bank_b_mem[wr_cnt_q] <= wr_dat;
        end
    end

    // ------------------------------------------------------------------
    // Read side FSM
    // ------------------------------------------------------------------
    rd_state_e        state_q, state_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_issue;
    logic [LOG2N-1:0] rd_addr;

    assign rd_addr = bitrev(rd_cnt_q);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_issue  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (handover_q) begin
                    state_d   = S_STREAM;
                    rd_cnt_d  = '0;
                    rd_bank_d = handover_bank_q;
                end
            end
            S_STREAM: begin
                rd_issue = 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == CNT_LAST) begin
                    // A frame finishing on exactly this cycle chains straight on,
                    // which is what makes continuous input give continuous output.
                    if (handover_q) begin
                        rd_cnt_d  = '0;
                        rd_bank_d = handover_bank_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // ------------------------------------------------------------------
    // Synchronous read doubles as the output register stage
    // ------------------------------------------------------------------
    sample_t rd_dat_q;
    logic    out_vld_q;
    logic    out_first_q;

    always_ff @(posedge clock) begin
        if (rd_issue) begin
            rd_dat_q <= rd_bank_q ? bank_b_mem[rd_addr] : bank_a_mem[rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_vld_q   <= 1'b0;
            out_first_q <= 1'b0;
        end else begin
            out_vld_q   <= rd_issue;
            out_first_q <= rd_issue && (rd_cnt_q == '0);
        end
    end

    // Data register is not reset; gate it so idle cycles always show zero.
    assign output_en   = out_vld_q;
    assign frame_start = out_first_q;
    assign output_real = out_vld_q ? rd_dat_q.re : '0;
    assign output_imag = out_vld_q ? rd_dat_q.im : '0;

endmodule

// File: tb/tb_bit_reverse_reorder.sv
module tb_bit_reverse_reorder;

    localparam int W   = 32;
    localparam int N   = 256;
    localparam int LG  = 8;
    localparam int N16 = 16;
    localparam int LG16 = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Main DUT (N=256)
    logic         en = 1'b0;
    logic [W-1:0] re = '0;
    logic [W-1:0] im = '0;
    logic         o_en;
    logic [W-1:0] o_re;
    logic [W-1:0] o_im;
    logic         o_fs;

    // Small DUT (N=16)
    logic         en16 = 1'b0;
    logic [W-1:0] re16 = '0;
    logic [W-1:0] im16 = '0;
    logic         o16_en;
    logic [W-1:0] o16_re;
    logic [W-1:0] o16_im;
    logic         o16_fs;

    bit_reverse_reorder #(.WIDTH(W), .N(N), .LOG2N(LG)) dut (
        .clock       (clock),
        .reset       (reset),
        .input_en    (en),
        .input_real  (re),
        .input_imag  (im),
        .output_en   (o_en),
        .output_real (o_re),
        .output_imag (o_im),
        .frame_start (o_fs)
    );

    bit_reverse_reorder #(.WIDTH(W), .N(N16), .LOG2N(LG16)) dut16 (
        .clock       (clock),
        .reset       (reset),
        .input_en    (en16),
        .input_real  (re16),
        .input_imag  (im16),
        .output_en   (o16_en),
        .output_real (o16_re),
        .output_imag (o16_im),
        .frame_start (o16_fs)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: collect a frame, then schedule its outputs
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         fs;
    } exp_t;

    exp_t           expq[$];
    logic [2*W-1:0] frame[$];
    exp_t           mexp;
    logic [2*W-1:0] mdat;
    int unsigned    last_acc = 0;
    int unsigned    last16_acc = 0;

    function automatic int unsigned brev(input int unsigned k, input int bits);
        int unsigned r;
        r = 0;
        for (int b = 0; b < bits; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            frame.delete();
            expq.delete();
        end else begin
            if (en16) last16_acc = cyc;
            if (en) begin
                last_acc = cyc;
                frame.push_back({re, im});
                if (frame.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        mdat     = frame[brev(k, LG)];
                        mexp.cyc = cyc + 2 + k;
                        mexp.re  = mdat[2*W-1:W];
                        mexp.im  = mdat[W-1:0];
                        mexp.fs  = (k == 0);
                        expq.push_back(mexp);
                    end
                    frame.delete();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output monitor / scoreboard for the main DUT
    // ------------------------------------------------------------------
    logic         mon_on = 1'b0;
    int           out_cnt = 0;
    int           fs_cnt = 0;
    int           run_cur = 0;
    int           run_max = 0;
    int unsigned  first_out_cyc = 0;
    int unsigned  fs_cyc[$];
    logic [W-1:0] olog[$];
    exp_t         mpop;

    always @(negedge clock) begin
        if (mon_on) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_out cyc=%0d got none expected re=%0h", expq[0].cyc, expq[0].re);
                void'(expq.pop_front());
            end
            if (o_en) begin
                if (out_cnt == 0) first_out_cyc = cyc;
                out_cnt++;
                run_cur++;
                if (run_cur > run_max) run_max = run_cur;
                olog.push_back(o_re);
                if (o_fs) begin
                    fs_cnt++;
                    fs_cyc.push_back(cyc);
                end
                checks++;
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_out cyc=%0d got re=%0h expected no output", cyc, o_re);
                end else begin
                    mpop = expq.pop_front();
                    if ({o_re, o_im, o_fs} !== {mpop.re, mpop.im, mpop.fs}) begin
                        errors++;
                        $display("FAIL out_data cyc=%0d got re=%0h im=%0h fs=%0b expected re=%0h im=%0h fs=%0b",
                                 cyc, o_re, o_im, o_fs, mpop.re, mpop.im, mpop.fs);
                    end
                end
            end else begin
                run_cur = 0;
                checks++;
                if ({o_re, o_im, o_fs} !== '0) begin
                    errors++;
                    $display("FAIL idle_zero cyc=%0d got re=%0h im=%0h fs=%0b expected 0", cyc, o_re, o_im, o_fs);
                end
                checks++;
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    errors++;
                    $display("FAIL missing_out cyc=%0d got output_en=0 expected re=%0h", cyc, expq[0].re);
                    void'(expq.pop_front());
                end
            end
        end
    end

    // Log for the small DUT
    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         fs;
    } log16_t;
    log16_t log16[$];
    log16_t l16;

    always @(negedge clock) begin
        if (o16_en) begin
            l16.cyc = cyc;
            l16.re  = o16_re;
            l16.im  = o16_im;
            l16.fs  = o16_fs;
            log16.push_back(l16);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input logic [W-1:0] r, input logic [W-1:0] i);
        @(posedge clock); #1;
        en = 1'b1; re = r; im = i;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            en = 1'b0;
        end
    endtask

    task automatic push16(input logic [W-1:0] r, input logic [W-1:0] i);
        @(posedge clock); #1;
        en16 = 1'b1; re16 = r; im16 = i;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout got pending=%0d expected 0", name, expq.size());
        end
        idle(3);
    endtask

    task automatic clear_stats();
        out_cnt = 0; fs_cnt = 0; run_cur = 0; run_max = 0; first_out_cyc = 0;
        fs_cyc.delete();
        olog.delete();
    endtask

    function automatic logic [W-1:0] olog_at(input int i);
        if (i < olog.size()) return olog[i];
        return 32'hDEADBEEF;
    endfunction

    function automatic int unsigned fs_at(input int i);
        if (i < fs_cyc.size()) return fs_cyc[i];
        return 0;
    endfunction

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] in_re;
        logic [W-1:0] in_im;
        logic [W-1:0] exp_re;
        logic [W-1:0] exp_im;
    } vec_t;

    vec_t tbl[N16];
    int   ord16[N16];
    int   stale;
    int   s_cnt;
    int   n;
    int   c;
    int   k;
    logic gaps;
    logic [W-1:0] r16;
    log16_t g;

    initial begin
        // N=16 vector table: real=k, imag=-k, two samples carrying extreme values.
        ord16 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int i = 0; i < N16; i++) begin
            tbl[i].in_re  = W'(i);
            tbl[i].in_im  = W'(-i);
            tbl[i].exp_re = W'(ord16[i]);
            tbl[i].exp_im = W'(-ord16[i]);
        end
        tbl[3].in_re   = 32'h80000000;
        tbl[3].in_im   = 32'h7FFFFFFF;
        tbl[12].exp_re = 32'h80000000;
        tbl[12].exp_im = 32'h7FFFFFFF;
        tbl[5].in_re   = 32'hFFFFFFFF;
        tbl[5].in_im   = 32'h80000000;
        tbl[10].exp_re = 32'hFFFFFFFF;
        tbl[10].exp_im = 32'h80000000;

        // Reset state
        repeat (3) @(posedge clock);
        #1 mon_on = 1'b1;
        @(negedge clock);
        chk("reset_output_en", o_en, 0);
        chk("reset_output_real", o_re, 0);
        chk("reset_frame_start", o_fs, 0);
        chk("reset_output_en16", o16_en, 0);
        @(posedge clock); #1 reset = 1'b0;
        idle(2);

        // 1: continuous ramp
        clear_stats();
        for (int i = 0; i < N; i++) push(W'(i), W'(-i));
        idle(1);
        drain("ramp", 600);
        chk("ramp_count", out_cnt, 256);
        chk("ramp_contiguous", run_max, 256);
        chk("ramp_fs_count", fs_cnt, 1);
        chk("ramp_latency", first_out_cyc - last_acc, 2);
        chk("ramp_out0", olog_at(0), 0);
        chk("ramp_out1", olog_at(1), 128);
        chk("ramp_out2", olog_at(2), 64);
        chk("ramp_out3", olog_at(3), 192);
        chk("ramp_out255", olog_at(255), 255);

        // 2: ramp with input_en low every third cycle
        clear_stats();
        k = 0; c = 0;
        while (k < N) begin
            if (c % 3 == 2) idle(1);
            else begin
                push(W'(k), W'(-k));
                k++;
            end
            c++;
        end
        idle(1);
        drain("gapped", 600);
        chk("gapped_count", out_cnt, 256);
        chk("gapped_latency", first_out_cyc - last_acc, 2);
        chk("gapped_out1", olog_at(1), 128);
        chk("gapped_out4", olog_at(4), 32);

        // 3: two frames back-to-back
        clear_stats();
        for (int i = 0; i < N; i++) push(W'(i), W'(-i));
        for (int i = 0; i < N; i++) push(W'(1000 + i), W'(-(1000 + i)));
        idle(1);
        drain("b2b", 900);
        chk("b2b_count", out_cnt, 512);
        chk("b2b_contiguous", run_max, 512);
        chk("b2b_fs_count", fs_cnt, 2);
        chk("b2b_fs_spacing", fs_at(1) - fs_at(0), 256);
        chk("b2b_out256", olog_at(256), 1000);
        chk("b2b_out257", olog_at(257), 1128);

        // 4: reset after 100 samples, then a full frame
        clear_stats();
        for (int i = 0; i < 100; i++) push(W'(5000 + i), W'(i));
        @(posedge clock); #1 en = 1'b0; reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < N; i++) push(W'(i), W'(7));
        idle(1);
        drain("partial", 600);
        chk("partial_count", out_cnt, 256);
        stale = 0;
        for (int i = 0; i < olog.size(); i++)
            if (olog[i] >= 5000 && olog[i] < 5100) stale++;
        chk("partial_no_stale", stale, 0);

        // 5: reset in the middle of the output stream
        clear_stats();
        for (int i = 0; i < N; i++) push(W'(2000 + i), W'(i));
        idle(1);
        n = 0;
        while (out_cnt < 51 && n < 400) begin
            @(posedge clock);
            n++;
        end
        chk("midreset_reached_out50", out_cnt >= 51, 1);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("midreset_output_en", o_en, 0);
        chk("midreset_output_real", o_re, 0);
        chk("midreset_output_imag", o_im, 0);
        chk("midreset_frame_start", o_fs, 0);
        @(posedge clock); #1;
        s_cnt = out_cnt;
        chk("midreset_outputs_before_cut", s_cnt, 52);
        idle(300);
        chk("midreset_silent", out_cnt - s_cnt, 0);
        for (int i = 0; i < N; i++) push(W'(3000 + i), W'(i));
        idle(1);
        drain("recover", 600);
        chk("recover_count", out_cnt - s_cnt, 256);

        // 6: random data, random gaps, mixed with back-to-back frames
        clear_stats();
        for (int f = 0; f < 3; f++) begin
            gaps = (f == 1);
            for (int i = 0; i < N; i++) begin
                while (gaps && $urandom_range(0, 3) == 0) idle(1);
                push(W'($urandom), W'($urandom));
            end
        end
        idle(1);
        drain("random", 1500);
        chk("random_count", out_cnt, 768);
        chk("random_fs_count", fs_cnt, 3);

        // 7: N=16 table, including extreme negative/positive values
        log16.delete();
        for (int i = 0; i < N16; i++) push16(tbl[i].in_re, tbl[i].in_im);
        @(posedge clock); #1 en16 = 1'b0;
        repeat (25) @(posedge clock);
        #1;
        chk("n16_count", log16.size(), 16);
        for (int i = 0; i < N16; i++) begin
            if (i < log16.size()) g = log16[i];
            else begin
                g.cyc = 0; g.re = 32'hDEADBEEF; g.im = 32'hDEADBEEF; g.fs = 1'bx;
            end
            r16 = tbl[i].exp_re;
            chk($sformatf("n16_re_%0d", i), g.re, r16);
            chk($sformatf("n16_im_%0d", i), g.im, tbl[i].exp_im);
            chk($sformatf("n16_fs_%0d", i), g.fs, (i == 0));
            chk($sformatf("n16_cyc_%0d", i), g.cyc, last16_acc + 2 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
